// File: rtl/parallel_to_serial_wrapper_if.sv
// Parallel-side control and serial-side outputs of the parallel-to-serial transmitter.
interface parallel_to_serial_wrapper_if #(
  parameter int WIDTH = 64
);
  logic             Enable;
  logic [WIDTH-1:0] framesize;
  logic             load_send;
  logic [WIDTH-1:0] parallel;
  logic             serial;
  logic             complete;

  modport master (
    output Enable,
    output framesize,
    output load_send,
    output parallel,
    input  serial,
    input  complete
  );

  modport slave (
    input  Enable,
    input  framesize,
    input  load_send,
    input  parallel,
    output serial,
    output complete
  );
endinterface

// File: rtl/parallel_to_serial_wrapper.sv
// Captures a parallel word on load_send and shifts out min(framesize, WIDTH) bits MSB-first,
// then holds complete until load_send is released.
//
// state | meaning
// IDLE  | outputs low, waiting for load_send
// SEND  | shifting the captured frame out, one bit per enabled edge
// DONE  | frame finished, complete high until load_send drops
module parallel_to_serial_wrapper #(
  parameter int WIDTH = 64
) (
  input logic                      Clock,
  input logic                      Reset,
  parallel_to_serial_wrapper_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    len_q, len_d;
  logic [CW-1:0]    len_cap;
  logic [CW-1:0]    shamt;

  // Oversized frame requests are clamped so the counter never needs to exceed WIDTH.
  always_comb begin
    if (bus.framesize > WIDTH'(WIDTH)) begin
      len_cap = CW'(WIDTH);
    end else begin
      len_cap = bus.framesize[CW-1:0];
    end
    shamt = CW'(WIDTH) - len_cap;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (bus.Enable) begin
      case (state_q)
        IDLE: begin
          if (bus.load_send) begin
            // A zero-length frame shifts by WIDTH, leaving the register cleared.
            shreg_d = bus.parallel << shamt;
            cnt_d   = '0;
            len_d   = len_cap;
            state_d = (len_cap == '0) ? DONE : SEND;
          end
        end
        SEND: begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == len_q - CW'(1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (!bus.load_send) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.serial   = (state_q == SEND) && shreg_q[WIDTH-1];
  assign bus.complete = (state_q == DONE);

endmodule

// File: tb/tb_parallel_to_serial_wrapper.sv
// Directed bench for parallel_to_serial_wrapper with an expected-bit scoreboard queue.
module tb_parallel_to_serial_wrapper;
  localparam int W = 64;

  logic Clock = 1'b0;
  logic Reset;

  parallel_to_serial_wrapper_if #(.WIDTH(W)) bus ();

  parallel_to_serial_wrapper #(.WIDTH(W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int   vectors     = 0;
  int   miscompares = 0;
  logic sb_q[$];

  task automatic step();
    @(posedge Clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame from IDLE; stall_at/abort_at are bit indices (-1 = none).
  task automatic run_frame(input logic [W-1:0] par, input logic [W-1:0] fs, input bit hold,
                           input int stall_at, input int stall_len, input int abort_at);
    int   n;
    int   k;
    logic b;
    bus.parallel  = par;
    bus.framesize = fs;
    bus.load_send = 1'b1;
    bus.Enable    = 1'b1;
    n = (fs > W) ? W : int'(fs);
    for (int i = n - 1; i >= 0; i--) sb_q.push_back(par[i]);
    step();
    bus.parallel  = ~par;
    bus.framesize = 64'd5;
    if (!hold) bus.load_send = 1'b0;
    k = 0;
    while (sb_q.size() > 0) begin
      b = sb_q.pop_front();
      chk($sformatf("serial_bit%0d", k), bus.serial, b);
      chk("complete_busy", bus.complete, 1'b0);
      if (k == abort_at) begin
        #1 Reset = 1'b0;
        #1;
        chk("abort_serial", bus.serial, 1'b0);
        chk("abort_complete", bus.complete, 1'b0);
        sb_q.delete();
        step();
        chk("abort_hold_complete", bus.complete, 1'b0);
        Reset = 1'b1;
        return;
      end
      if (k == stall_at) begin
        bus.Enable = 1'b0;
        repeat (stall_len) begin
          step();
          chk("stall_serial", bus.serial, b);
          chk("stall_complete", bus.complete, 1'b0);
        end
        bus.Enable = 1'b1;
      end
      step();
      k++;
    end
    chk("done_serial", bus.serial, 1'b0);
    chk("done_complete", bus.complete, 1'b1);
    if (hold) begin
      repeat (2) begin
        step();
        chk("held_complete", bus.complete, 1'b1);
        chk("held_serial", bus.serial, 1'b0);
      end
      bus.load_send = 1'b0;
    end
    step();
    chk("idle_complete", bus.complete, 1'b0);
    chk("idle_serial", bus.serial, 1'b0);
  endtask

  initial begin
    Reset         = 1'b0;
    bus.Enable    = 1'b1;
    bus.load_send = 1'b1;
    bus.parallel  = 64'hDEAD_BEEF_0000_FFFF;
    bus.framesize = 64'd0;
    repeat (3) begin
      step();
      chk("reset_serial", bus.serial, 1'b0);
      chk("reset_complete", bus.complete, 1'b0);
    end
    Reset = 1'b1;

    // Short frame, captured on the first edge after reset release.
    run_frame(64'h0000_0000_0000_00A5, 64'd8, 1'b0, -1, 0, -1);
    // Full frame with load_send held.
    run_frame(64'hF0F0_F0F0_F0F0_F0F0, 64'd64, 1'b1, -1, 0, -1);
    // Full frame with a 5-cycle enable stall after 10 bits.
    run_frame(64'hF0F0_F0F0_F0F0_F0F0, 64'd64, 1'b1, 9, 5, -1);

    // Enable low must block a capture that would otherwise go straight to DONE.
    bus.Enable    = 1'b0;
    bus.load_send = 1'b1;
    bus.framesize = 64'd0;
    repeat (3) begin
      step();
      chk("disabled_complete", bus.complete, 1'b0);
    end
    bus.Enable    = 1'b1;
    bus.load_send = 1'b0;
    step();
    chk("disabled_idle", bus.complete, 1'b0);

    run_frame(64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, -1, 0, -1);
    run_frame(64'h0123_4567_89AB_CDEF, 64'd100, 1'b1, -1, 0, -1);
    run_frame(64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1, 0, -1);
    run_frame(64'h0000_0000_0000_0001, 64'd1, 1'b0, -1, 0, -1);
    run_frame(64'h0000_0000_0000_0D3C, 64'd13, 1'b0, 4, 2, -1);

    // Async reset during bit 20, then a fresh frame.
    run_frame(64'hF0F0_F0F0_F0F0_F0F0, 64'd64, 1'b1, -1, 0, 20);
    run_frame(64'hCAFE_BABE_1234_5678, 64'd64, 1'b1, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
